retire_trace_sink: RTL

Receiving end of the single-cycle core's retire-trace and debug-read ports. Captures every retired instruction record (`update`, pc, instr, register and memory writeback) into a FIFO and drains it through a valid/ready stream. When the program reaches its end PC, it walks a configured data-memory window through the core's read port (`addr_i`/`data_o`) and streams the words out. It sits between the core top and the test harness or trace logger.

---
 rtl/retire_trace_sink_if.sv | 44 ++++
 rtl/retire_trace_sink.sv | 126 ++++++++++++
 2 files changed

// File: rtl/retire_trace_sink_if.sv
// Bundle between the core's retire/debug-read ports and the retire trace sink.
// slave is the sink side; master is the core/harness side.
interface retire_trace_sink_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = 5 * XLEN + 6;

    logic            update_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic [4:0]      reg_addr_i;
    logic [XLEN-1:0] reg_data_i;
    logic [XLEN-1:0] mem_addr_i;
    logic [XLEN-1:0] mem_data_i;
    logic            mem_wrt_i;
    logic [XLEN-1:0] addr_o;
    logic [XLEN-1:0] data_i;
    logic            tr_valid_o;
    logic            tr_ready_i;
    logic [RW-1:0]   tr_data_o;
    logic            dump_valid_o;
    logic            dump_ready_i;
    logic [XLEN-1:0] dump_addr_o;
    logic [XLEN-1:0] dump_data_o;
    logic [CW-1:0]   count_o;
    logic            overflow_o;
    logic            done_o;

    modport slave (
        input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i, mem_data_i, mem_wrt_i,
        input  data_i, tr_ready_i, dump_ready_i,
        output addr_o, tr_valid_o, tr_data_o, dump_valid_o, dump_addr_o, dump_data_o,
        output count_o, overflow_o, done_o
    );

    modport master (
        output update_i, pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i, mem_data_i, mem_wrt_i,
        output data_i, tr_ready_i, dump_ready_i,
        input  addr_o, tr_valid_o, tr_data_o, dump_valid_o, dump_addr_o, dump_data_o,
        input  count_o, overflow_o, done_o
    );
endinterface

// File: rtl/retire_trace_sink.sv
// Captures retired-instruction records into a show-ahead FIFO, then at program
// end walks a data-memory window through the core's read port and streams it out.
module retire_trace_sink #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 16,
    parameter logic [XLEN-1:0] END_PC     = 32'h8000_20c8,
    parameter logic [XLEN-1:0] DUMP_BASE  = 32'h8000_0000,
    parameter int unsigned     DUMP_WORDS = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    retire_trace_sink_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 5 * XLEN + 6;
    localparam int unsigned IW = (DUMP_WORDS == 0) ? 1 : $clog2(DUMP_WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DUMP_WORDS - 1);

    typedef enum logic [2:0] {CAPTURE, DRAIN, DUMP_ADDR, DUMP_OUT, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] addr_q;
    logic            dump_valid_q;
    logic [XLEN-1:0] dump_addr_q;
    logic [XLEN-1:0] dump_data_q;
    logic            done_q;
    logic            push_req;
    logic            full;
    logic            pop;
    logic            push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        push_req = 1'b0;
        if (state == CAPTURE && bus.update_i && bus.pc_i != END_PC) push_req = 1'b1;
        full = (count == CW'(DEPTH));
        pop  = (count != '0) && bus.tr_ready_i;
        push = push_req && (!full || pop);
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= {bus.pc_i, bus.instr_i, bus.reg_addr_i, bus.reg_data_i,
                            bus.mem_addr_i, bus.mem_data_i, bus.mem_wrt_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= CAPTURE;
            idx          <= '0;
            addr_q       <= DUMP_BASE;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            unique case (state)
                CAPTURE: if (bus.pc_i == END_PC) state <= DRAIN;
                DRAIN: begin
                    if (count == '0) begin
                        if (DUMP_WORDS == 0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= DUMP_ADDR;
                        end
                    end
                end
                // addr_o has been stable for a full cycle here, so data_i is settled.
                DUMP_ADDR: begin
                    dump_data_q  <= bus.data_i;
                    dump_addr_q  <= addr_q;
                    dump_valid_q <= 1'b1;
                    state        <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (bus.dump_ready_i) begin
                        dump_valid_q <= 1'b0;
                        idx          <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + XLEN'(4);
                            state  <= DUMP_ADDR;
                        end
                    end
                end
                DONE: state <= DONE;
                default: state <= CAPTURE;
            endcase
        end
    end

    assign bus.tr_valid_o   = (count != '0);
    assign bus.tr_data_o    = mem[rd_ptr];
    assign bus.count_o      = count;
    assign bus.overflow_o   = overflow;
    assign bus.addr_o       = addr_q;
    assign bus.dump_valid_o = dump_valid_q;
    assign bus.dump_addr_o  = dump_addr_q;
    assign bus.dump_data_o  = dump_data_q;
    assign bus.done_o       = done_q;
endmodule
